mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
//   Multi-cycle MIPS control unit: a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB.
//   Decodes the IR once per instruction and emits per-cycle datapath enables and memory requests.
//   Waits on a shared instruction/data memory via a req/ready handshake, with an optional timeout.
//   Successor to the single-cycle decoder; datapath select encodings are unchanged.
// PARAMETERS
//   TIMEOUT   16  max wait cycles for mem_ready per access; 0 = wait forever
//   EN_LINK   1   1 = jal supported; 0 = jal decodes as illegal
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous, active-low reset
//   instr      in   32  IR contents (valid from DECODE on)
//   zero       in   1   ALU zero flag (sampled in EXEC for beq)
//   mem_ready  in   1   memory access complete this cycle
//   mem_req    out  1   memory access request (held until ready/timeout)
//   memwrite   out  1   write qualifier for mem_req
//   ir_write   out  1   load IR (1-cycle strobe)
//   pc_write   out  1   load PC from npc mux (1-cycle strobe)
//   npc_sel    out  1   0 = PC+4, 1 = branch target
//   jump       out  1   PC from jump/jr target
//   regwrite   out  1   register file write strobe
//   regdist    out  2   00 rt, 01 rd, 10 $31
//   alusrc     out  2   00 rt, 01 extended imm
//   extop      out  2   00 sign, 01 zero, 10 lui-upper, 11 sign<<2
//   regsrc     out  2   00 ALU, 01 memory, 10 PC+4
//   aluop      out  4   0010 add, 0011 sub, 0101 or, 1100 slt
//   state      out  3   FSM state: 0 FETCH 1 DECODE 2 EXEC 3 MEM 4 WB
//   illegal    out  1   1-cycle pulse in DECODE on an unsupported opcode/funct
//   bus_err    out  1   1-cycle pulse when a memory wait hits TIMEOUT
// BEHAVIOUR
// - rst_n=0 at an edge: state<=FETCH, latched control word<=0, wait counter<=0.
//   All outputs are 0 while rst_n=0. Reset mid-access abandons it; no strobes fire.
// - FETCH: mem_req=1, memwrite=0.
//   On mem_ready: ir_write=1 and pc_write=1 (npc_sel=0, jump=0) in the same cycle; then ->DECODE.
// - DECODE: register the control word from instr.
//   Supported: addu/subu/slt/jr (op 0), j, jal, beq, addi, addiu, slti, ori, lui,
//   lb/lh/lw/lbu/lhu, sb/sh/sw. Encodings as listed under PORTS.
//   instr==0 (nop): ->FETCH.
//   Unsupported instr: illegal=1 for 1 cycle, treated as nop, ->FETCH.
//   All others: ->EXEC.
// - EXEC: aluop/alusrc/extop driven from the latched word.
//   j/jr: pc_write=1, jump=1; ->FETCH.
//   jal: pc_write=1, jump=1, regwrite=1, regdist=10, regsrc=10; ->FETCH.
//   beq: pc_write=zero, npc_sel=1; ->FETCH.
//   Loads/stores: ->MEM. ALU ops: ->WB.
// - MEM: mem_req=1; memwrite=1 for stores.
//   On mem_ready: loads ->WB, stores ->FETCH.
// - WB: regwrite=1 for exactly 1 cycle; regsrc 01 for loads, 00 for ALU ops; ->FETCH.
// - Wait counter: cleared on entering FETCH/MEM; increments each cycle mem_req=1 && !mem_ready.
//   If TIMEOUT!=0 and count reaches TIMEOUT-1 without ready: bus_err=1 and ->FETCH.
//   On timeout, no ir_write/pc_write/regwrite fires for that access.
//   mem_ready on the last allowed cycle wins over timeout.
// - mem_ready outside FETCH/MEM is ignored. Control fields hold their value in
//   non-strobe states; strobes are 0 outside their listed cycle.
// - Latency, zero-wait memory: ALU op 4 cycles, load 5, store 4, branch/jump 3, nop 2.
// TESTING
// 1 Reset low 3 cycles mid-MEM then release -> all outputs 0 during reset; state=0 and mem_req=1 next cycle.
// 2 addu $3,$1,$2 (0x00221821), ready immediate -> states 0,1,2,4; WB: regwrite=1, regdist=01, aluop=0010.
// 3 lw (0x8C220004), ready after 3 wait cycles in MEM -> mem_req held 4 cycles; WB: regsrc=01, regwrite=1.
// 4 beq with zero=1 and zero=0 -> pc_write=1/npc_sel=1, then pc_write=0; extop=11 in EXEC; no regwrite.
// 5 TIMEOUT=4, mem_ready never in FETCH -> bus_err pulse on 4th wait cycle; back in FETCH, no ir_write.
// 6 opcode 0x3F; EN_LINK=0 with jal -> illegal pulse in DECODE, ->FETCH, no writes.

Source files
------------

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
//   Multi-cycle MIPS control unit. A Moore FSM that steps each instruction
//   through FETCH / DECODE / EXEC / MEM / WB. The IR is decoded once, in
//   DECODE, into a latched control word. That word drives the datapath select
//   fields until the next instruction is decoded. Memory is shared between
//   instruction and data accesses and uses a req/ready handshake. When
//   TIMEOUT is non-zero, a stalled access is abandoned with a bus_err pulse.
//
// Parameters
//   TIMEOUT   max wait cycles for mem_ready per access (0 = wait forever)
//   EN_LINK   1 = jal supported, 0 = jal decodes as illegal
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (all outputs 0 while low)
//   instr      in   IR contents, valid from DECODE onward
//   zero       in   ALU zero flag, used in EXEC for beq
//   mem_ready  in   memory access completes this cycle
//   mem_req    out  memory request, held until ready or timeout
//   memwrite   out  write qualifier for mem_req
//   ir_write   out  load IR strobe
//   pc_write   out  load PC strobe
//   npc_sel    out  0 = PC+4, 1 = branch target
//   jump       out  PC from jump / jr target
//   regwrite   out  register file write strobe
//   regdist    out  00 rt, 01 rd, 10 $31
//   alusrc     out  00 rt, 01 extended immediate
//   extop      out  00 sign, 01 zero, 10 lui-upper, 11 sign<<2
//   regsrc     out  00 ALU, 01 memory, 10 PC+4
//   aluop      out  0010 add, 0011 sub, 0101 or, 1100 slt
//   state      out  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
//   illegal    out  DECODE pulse on an unsupported instruction
//   bus_err    out  pulse when a memory wait times out
// ---------------------------------------------------------------------------
module mc_control #(
    parameter int TIMEOUT = 16,
    parameter bit EN_LINK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        ir_write,
    output logic        pc_write,
    output logic        npc_sel,
    output logic        jump,
    output logic        regwrite,
    output logic [1:0]  regdist,
    output logic [1:0]  alusrc,
    output logic [1:0]  extop,
    output logic [1:0]  regsrc,
    output logic [3:0]  aluop,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Instruction class: selects the EXEC/MEM/WB path taken
    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_ALU   = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_BEQ   = 3'd4,
        C_JUMP  = 3'd5,
        C_JAL   = 3'd6
    } cls_e;

    typedef struct packed {
        cls_e       cls;
        logic [3:0] aluop;
        logic [1:0] alusrc;
        logic [1:0] extop;
        logic [1:0] regdist;
        logic [1:0] regsrc;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b1100;

    localparam logic [1:0] SRC_RT  = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_BR   = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Counter only needs to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic ctrl_t make_word(input cls_e c, input logic [3:0] op,
                                        input logic [1:0] src, input logic [1:0] ext,
                                        input logic [1:0] dst, input logic [1:0] wb);
        ctrl_t w;
        w.cls     = c;
        w.aluop   = op;
        w.alusrc  = src;
        w.extop   = ext;
        w.regdist = dst;
        w.regsrc  = wb;
        return w;
    endfunction

    state_e          state_q, state_d;
    ctrl_t           word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_t      dec_word;
    logic       dec_ok;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       at_limit;

    logic mem_req_c, memwrite_c, ir_write_c, pc_write_c;
    logic npc_sel_c, jump_c, regwrite_c, illegal_c, bus_err_c;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // -----------------------------------------------------------------------
    // Instruction decode
    // -----------------------------------------------------------------------
    always_comb begin
        dec_word = '0;
        dec_ok   = 1'b1;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   dec_word = make_word(C_ALU, ALU_ADD, SRC_RT, EXT_SIGN, DST_RD, WB_ALU);
                    6'h23:   dec_word = make_word(C_ALU, ALU_SUB, SRC_RT, EXT_SIGN, DST_RD, WB_ALU);
                    6'h2A:   dec_word = make_word(C_ALU, ALU_SLT, SRC_RT, EXT_SIGN, DST_RD, WB_ALU);
                    6'h08:   dec_word = make_word(C_JUMP, 4'b0000, SRC_RT, EXT_SIGN, DST_RT, WB_ALU);
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h02: dec_word = make_word(C_JUMP, 4'b0000, SRC_RT, EXT_SIGN, DST_RT, WB_ALU);
            6'h03: begin
                if (EN_LINK) begin
                    dec_word = make_word(C_JAL, 4'b0000, SRC_RT, EXT_SIGN, DST_RA, WB_PC4);
                end else begin
                    dec_ok = 1'b0;
                end
            end
            6'h04: dec_word = make_word(C_BEQ, ALU_SUB, SRC_RT, EXT_BR, DST_RT, WB_ALU);
            6'h08,
            6'h09: dec_word = make_word(C_ALU, ALU_ADD, SRC_IMM, EXT_SIGN, DST_RT, WB_ALU);
            6'h0A: dec_word = make_word(C_ALU, ALU_SLT, SRC_IMM, EXT_SIGN, DST_RT, WB_ALU);
            6'h0D: dec_word = make_word(C_ALU, ALU_OR, SRC_IMM, EXT_ZERO, DST_RT, WB_ALU);
            // lui: rs is $0, so an add passes the upper-shifted immediate
            6'h0F: dec_word = make_word(C_ALU, ALU_ADD, SRC_IMM, EXT_LUI, DST_RT, WB_ALU);
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                   dec_word = make_word(C_LOAD, ALU_ADD, SRC_IMM, EXT_SIGN, DST_RT, WB_MEM);
            6'h28, 6'h29, 6'h2B:
                   dec_word = make_word(C_STORE, ALU_ADD, SRC_IMM, EXT_SIGN, DST_RT, WB_ALU);
            default: dec_ok = 1'b0;
        endcase
    end

    // Last allowed wait cycle; a mem_ready on this cycle still completes
    assign at_limit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // -----------------------------------------------------------------------
    // Next-state and per-state outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = '0;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        npc_sel_c  = 1'b0;
        jump_c     = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        bus_err_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (at_limit) begin
                    // Abandon the fetch and retry with a fresh count
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DECODE: begin
                state_d = S_FETCH;
                word_d  = '0;
                if (instr != 32'd0) begin
                    if (dec_ok) begin
                        word_d  = dec_word;
                        state_d = S_EXEC;
                    end else begin
                        illegal_c = 1'b1;
                    end
                end
            end

            S_EXEC: begin
                case (word_q.cls)
                    C_JUMP: begin
                        pc_write_c = 1'b1;
                        jump_c     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_JAL: begin
                        pc_write_c = 1'b1;
                        jump_c     = 1'b1;
                        regwrite_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_BEQ: begin
                        pc_write_c = zero;
                        npc_sel_c  = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_ALU:           state_d = S_WB;
                    default:         state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req_c  = 1'b1;
                memwrite_c = (word_q.cls == C_STORE);
                if (mem_ready) begin
                    state_d = (word_q.cls == C_LOAD) ? S_WB : S_FETCH;
                end else if (at_limit) begin
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_WB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // While rst_n is low every output is forced to 0, so an access cut off
    // by reset never fires a strobe.
    assign mem_req  = rst_n & mem_req_c;
    assign memwrite = rst_n & memwrite_c;
    assign ir_write = rst_n & ir_write_c;
    assign pc_write = rst_n & pc_write_c;
    assign npc_sel  = rst_n & npc_sel_c;
    assign jump     = rst_n & jump_c;
    assign regwrite = rst_n & regwrite_c;
    assign illegal  = rst_n & illegal_c;
    assign bus_err  = rst_n & bus_err_c;

    assign regdist  = rst_n ? word_q.regdist : 2'b00;
    assign alusrc   = rst_n ? word_q.alusrc  : 2'b00;
    assign extop    = rst_n ? word_q.extop   : 2'b00;
    assign regsrc   = rst_n ? word_q.regsrc  : 2'b00;
    assign aluop    = rst_n ? word_q.aluop   : 4'b0000;
    assign state    = rst_n ? 3'(state_q)    : 3'd0;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control
//   Self-checking bench for mc_control (TIMEOUT=4, EN_LINK=0). Each scenario
//   task has a per-cycle stimulus/expectation table. Each row is pushed to the
//   scoreboard when its inputs are driven. The row is then popped and compared
//   against the DUT outputs at the following falling edge.
// ---------------------------------------------------------------------------
module tb_mc_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, memwrite, ir_write, pc_write, npc_sel, jump, regwrite;
    logic [1:0]  regdist, alusrc, extop, regsrc;
    logic [3:0]  aluop;
    logic [2:0]  state;
    logic        illegal, bus_err;

    mc_control #(
        .TIMEOUT (4),
        .EN_LINK (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .memwrite  (memwrite),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .npc_sel   (npc_sel),
        .jump      (jump),
        .regwrite  (regwrite),
        .regdist   (regdist),
        .alusrc    (alusrc),
        .extop     (extop),
        .regsrc    (regsrc),
        .aluop     (aluop),
        .state     (state),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, mem_req, memwrite, ir_write, pc_write, npc_sel, jump, regwrite, illegal, bus_err}
    logic [11:0] act_s;
    // {regdist, alusrc, extop, regsrc, aluop}
    logic [11:0] act_f;
    assign act_s = {state, mem_req, memwrite, ir_write, pc_write, npc_sel, jump, regwrite, illegal, bus_err};
    assign act_f = {regdist, alusrc, extop, regsrc, aluop};

    localparam logic [11:0] ZERO_ALL   = 12'b000_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] FETCH_HIT  = 12'b000_1_0_1_1_0_0_0_0_0;
    localparam logic [11:0] FETCH_WAIT = 12'b000_1_0_0_0_0_0_0_0_0;
    localparam logic [11:0] FETCH_TO   = 12'b000_1_0_0_0_0_0_0_0_1;
    localparam logic [11:0] DEC        = 12'b001_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] DEC_ILL    = 12'b001_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] EXEC_Q     = 12'b010_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] EXEC_J     = 12'b010_0_0_0_1_0_1_0_0_0;
    localparam logic [11:0] EXEC_BT    = 12'b010_0_0_0_1_1_0_0_0_0;
    localparam logic [11:0] EXEC_BN    = 12'b010_0_0_0_0_1_0_0_0_0;
    localparam logic [11:0] MEM_RD     = 12'b011_1_0_0_0_0_0_0_0_0;
    localparam logic [11:0] MEM_WR     = 12'b011_1_1_0_0_0_0_0_0_0;
    localparam logic [11:0] MEM_WR_TO  = 12'b011_1_1_0_0_0_0_0_0_1;
    localparam logic [11:0] WB_W       = 12'b100_0_0_0_0_0_0_1_0_0;

    localparam logic [11:0] F_NONE = 12'b00_00_00_00_0000;
    localparam logic [11:0] F_ADDU = 12'b01_00_00_00_0010;
    localparam logic [11:0] F_ORI  = 12'b00_01_01_00_0101;
    localparam logic [11:0] F_LW   = 12'b00_01_00_01_0010;
    localparam logic [11:0] F_SW   = 12'b00_01_00_00_0010;
    localparam logic [11:0] F_BEQ  = 12'b00_00_11_00_0011;

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_ORI  = 32'h3422_0005;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;

    typedef struct {
        logic        r;
        logic        rdy;
        logic        z;
        logic [31:0] ins;
        string       tag;
        logic [11:0] es;
        logic        cf;
        logic [11:0] ef;
    } row_t;

    row_t sb[$];
    int   checks;
    int   errors;

    function automatic row_t mk(input logic r, input logic rdy, input logic z,
                                input logic [31:0] ins, input string tag,
                                input logic [11:0] es, input logic cf, input logic [11:0] ef);
        row_t t;
        t.r = r; t.rdy = rdy; t.z = z; t.ins = ins;
        t.tag = tag; t.es = es; t.cf = cf; t.ef = ef;
        return t;
    endfunction

    // Drive one cycle of inputs just after the rising edge, record its
    // expectation, and return at the falling edge for sampling.
    task automatic drive(input row_t t);
        @(posedge clk);
        #1;
        rst_n     = t.r;
        mem_ready = t.rdy;
        zero      = t.z;
        instr     = t.ins;
        sb.push_back(t);
        @(negedge clk);
    endtask

    task automatic test_reset();
        row_t t[$];
        row_t e;
        t.push_back(mk(0, 0, 0, I_NOP, "rst_hold0", ZERO_ALL,   1, F_NONE));
        t.push_back(mk(0, 1, 0, I_NOP, "rst_hold1", ZERO_ALL,   1, F_NONE));
        t.push_back(mk(1, 1, 0, I_LW,  "rst_fetch", FETCH_HIT,  1, F_NONE));
        t.push_back(mk(1, 0, 0, I_LW,  "rst_dec",   DEC,        1, F_NONE));
        t.push_back(mk(1, 0, 0, I_LW,  "rst_exec",  EXEC_Q,     1, F_LW));
        t.push_back(mk(1, 0, 0, I_LW,  "rst_mem",   MEM_RD,     1, F_LW));
        t.push_back(mk(0, 1, 0, I_LW,  "rst_mid0",  ZERO_ALL,   1, F_NONE));
        t.push_back(mk(0, 1, 0, I_LW,  "rst_mid1",  ZERO_ALL,   1, F_NONE));
        t.push_back(mk(0, 1, 1, I_LW,  "rst_mid2",  ZERO_ALL,   1, F_NONE));
        t.push_back(mk(1, 0, 0, I_NOP, "rst_rel",   FETCH_WAIT, 1, F_NONE));
        t.push_back(mk(1, 1, 0, I_NOP, "nop_fetch", FETCH_HIT,  1, F_NONE));
        t.push_back(mk(1, 0, 0, I_NOP, "nop_dec",   DEC,        1, F_NONE));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_alu();
        row_t t[$];
        row_t e;
        // mem_ready held high outside FETCH must be ignored
        t.push_back(mk(1, 1, 0, I_ADDU, "addu_fetch", FETCH_HIT, 0, F_NONE));
        t.push_back(mk(1, 1, 0, I_ADDU, "addu_dec",   DEC,       0, F_NONE));
        t.push_back(mk(1, 1, 0, I_ADDU, "addu_exec",  EXEC_Q,    1, F_ADDU));
        t.push_back(mk(1, 1, 0, I_ADDU, "addu_wb",    WB_W,      1, F_ADDU));
        t.push_back(mk(1, 1, 0, I_ORI,  "ori_fetch",  FETCH_HIT, 1, F_ADDU));
        t.push_back(mk(1, 0, 0, I_ORI,  "ori_dec",    DEC,       1, F_ADDU));
        t.push_back(mk(1, 0, 0, I_ORI,  "ori_exec",   EXEC_Q,    1, F_ORI));
        t.push_back(mk(1, 0, 0, I_ORI,  "ori_wb",     WB_W,      1, F_ORI));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_load();
        row_t t[$];
        row_t e;
        t.push_back(mk(1, 1, 0, I_LW, "lw_fetch", FETCH_HIT, 1, F_ORI));
        t.push_back(mk(1, 0, 0, I_LW, "lw_dec",   DEC,       1, F_ORI));
        t.push_back(mk(1, 0, 0, I_LW, "lw_exec",  EXEC_Q,    1, F_LW));
        t.push_back(mk(1, 0, 0, I_LW, "lw_wait0", MEM_RD,    1, F_LW));
        t.push_back(mk(1, 0, 0, I_LW, "lw_wait1", MEM_RD,    1, F_LW));
        t.push_back(mk(1, 0, 0, I_LW, "lw_wait2", MEM_RD,    1, F_LW));
        // Ready on the last allowed wait cycle completes the access
        t.push_back(mk(1, 1, 0, I_LW, "lw_ready", MEM_RD,    1, F_LW));
        t.push_back(mk(1, 0, 0, I_LW, "lw_wb",    WB_W,      1, F_LW));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_store();
        row_t t[$];
        row_t e;
        t.push_back(mk(1, 1, 0, I_SW,  "sw_fetch",   FETCH_HIT, 1, F_LW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw_dec",     DEC,       1, F_LW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw_exec",    EXEC_Q,    1, F_SW));
        t.push_back(mk(1, 1, 0, I_SW,  "sw_mem",     MEM_WR,    1, F_SW));
        t.push_back(mk(1, 1, 0, I_SW,  "sw2_fetch",  FETCH_HIT, 1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_dec",    DEC,       1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_exec",   EXEC_Q,    1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_wait0",  MEM_WR,    1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_wait1",  MEM_WR,    1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_wait2",  MEM_WR,    1, F_SW));
        t.push_back(mk(1, 0, 0, I_SW,  "sw2_tmo",    MEM_WR_TO, 1, F_SW));
        t.push_back(mk(1, 1, 0, I_NOP, "sw2_refetch", FETCH_HIT, 1, F_SW));
        t.push_back(mk(1, 0, 0, I_NOP, "sw2_nopdec", DEC,       1, F_SW));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_beq();
        row_t t[$];
        row_t e;
        t.push_back(mk(1, 1, 1, I_BEQ, "beqt_fetch", FETCH_HIT, 1, F_NONE));
        t.push_back(mk(1, 0, 1, I_BEQ, "beqt_dec",   DEC,       1, F_NONE));
        t.push_back(mk(1, 0, 1, I_BEQ, "beqt_exec",  EXEC_BT,   1, F_BEQ));
        t.push_back(mk(1, 1, 0, I_BEQ, "beqn_fetch", FETCH_HIT, 1, F_BEQ));
        t.push_back(mk(1, 0, 0, I_BEQ, "beqn_dec",   DEC,       1, F_BEQ));
        t.push_back(mk(1, 0, 0, I_BEQ, "beqn_exec",  EXEC_BN,   1, F_BEQ));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_fetch_timeout();
        row_t t[$];
        row_t e;
        for (int k = 0; k < 2; k++) begin
            t.push_back(mk(1, 0, 0, I_NOP, "ft_wait0", FETCH_WAIT, 1, F_BEQ));
            t.push_back(mk(1, 0, 0, I_NOP, "ft_wait1", FETCH_WAIT, 1, F_BEQ));
            t.push_back(mk(1, 0, 0, I_NOP, "ft_wait2", FETCH_WAIT, 1, F_BEQ));
            t.push_back(mk(1, 0, 0, I_NOP, "ft_tmo",   FETCH_TO,   1, F_BEQ));
        end
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    task automatic test_illegal();
        row_t t[$];
        row_t e;
        t.push_back(mk(1, 1, 0, I_BAD, "bad_fetch", FETCH_HIT, 1, F_BEQ));
        t.push_back(mk(1, 0, 0, I_BAD, "bad_dec",   DEC_ILL,   0, F_NONE));
        t.push_back(mk(1, 1, 0, I_JAL, "jal_fetch", FETCH_HIT, 1, F_NONE));
        t.push_back(mk(1, 0, 0, I_JAL, "jal_dec",   DEC_ILL,   0, F_NONE));
        t.push_back(mk(1, 1, 0, I_SUB, "sub_fetch", FETCH_HIT, 1, F_NONE));
        t.push_back(mk(1, 0, 0, I_SUB, "sub_dec",   DEC_ILL,   0, F_NONE));
        t.push_back(mk(1, 1, 0, I_J,   "j_fetch",   FETCH_HIT, 1, F_NONE));
        t.push_back(mk(1, 0, 0, I_J,   "j_dec",     DEC,       1, F_NONE));
        t.push_back(mk(1, 0, 0, I_J,   "j_exec",    EXEC_J,    1, F_NONE));
        t.push_back(mk(1, 0, 0, I_NOP, "j_after",   FETCH_WAIT, 1, F_NONE));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            checks++;
            if (act_s !== e.es) begin
                errors++;
                $display("FAIL %s strobes: got %03h expected %03h", e.tag, act_s, e.es);
            end
            if (e.cf) begin
                checks++;
                if (act_f !== e.ef) begin
                    errors++;
                    $display("FAIL %s fields: got %03h expected %03h", e.tag, act_f, e.ef);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        instr     = 32'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_beq();
        test_fetch_timeout();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
